temporizador_mmss: RTL and testbench
====================================

# temporizador_mmss

MM:SS up/down timer with BCD outputs, driven by the 1 Hz divider output. It sits directly downstream of the 1 Hz divider and samples the divider's output square wave in the same `clk_in` domain. It detects each rising edge of that wave as one second and maintains a minutes/seconds count for the display stage. Start, stop, clear and preset-load commands come from the user-interface logic.

## Interface
Parameters:
- `MIN_MAX`, default 59: highest minutes value, BCD-legal decimal 1..99.

Ports:
- `clk_in`, input, 1: system clock; same clock that drives the divider.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `tick_in`, input, 1: 1 Hz divider output, a level in the `clk_in` domain. It is not a pulse, and its duty cycle is not 50 %.
- `start`, input, 1: one-cycle command; begin or resume counting.
- `stop`, input, 1: one-cycle command; pause counting.
- `clear`, input, 1: one-cycle command; count goes to 00:00 and the block returns to IDLE.
- `load`, input, 1: one-cycle command; copy the preset into the count.
- `up_down`, input, 1: 1 = count up, 0 = count down. Sampled on every tick.
- `preset_min`, input, 8: BCD minutes, {tens, units}.
- `preset_sec`, input, 8: BCD seconds, {tens, units}.
- `min_bcd`, output, 8: current minutes in BCD; reset value 8'h00.
- `sec_bcd`, output, 8: current seconds in BCD; reset value 8'h00.
- `running`, output, 1: high in the RUN state; reset value 0.
- `done`, output, 1: one-cycle pulse when a down-count reaches 00:00; reset value 0.
- `wrap`, output, 1: one-cycle pulse when an up-count wraps from MIN_MAX:59 to 00:00; reset value 0.
- `load_err`, output, 1: one-cycle pulse when a load is rejected; reset value 0.

## Operation
- Tick detection: register `tick_q` holds `tick_in` from the previous cycle.
  - `tick = tick_in & ~tick_q`.
  - `tick_q` resets to 1. This prevents a spurious tick if `tick_in` is already high when reset is released.
- States are IDLE, RUN, PAUSE and DONE. The reset state is IDLE.
  - IDLE --start--> RUN.
  - RUN --stop--> PAUSE.
  - PAUSE --start--> RUN.
  - RUN --(down-count reaches 00:00)--> DONE.
  - DONE --start--> RUN.
  - Any state --clear--> IDLE.
- Start guard: a start with `up_down`=0 and count = 00:00 is ignored, and the state is unchanged.
- Command priority within one cycle is clear > load > stop > start.
  - When start and stop arrive together, stop wins.
- Load:
  - Accepted in any state; the state is unchanged, except that DONE goes to IDLE.
  - Rejected when any of the following holds:
    - any BCD digit is greater than 9;
    - the seconds tens digit is greater than 5;
    - the minutes value is greater than MIN_MAX.
  - On rejection the count is unchanged and `load_err` pulses.
- Counting happens only in RUN, and only on `tick`.
- Up-count:
  - Seconds units run 9→0 with a carry into seconds tens.
  - Seconds tens run 5→0 with a carry into minutes.
  - At MIN_MAX:59 the count goes to 00:00, `wrap` pulses, and counting continues.
- Down-count:
  - Units run 0→9 with a borrow; seconds tens run 0→5 with a borrow.
  - When the count goes from 00:01 to 00:00, `done` pulses and the state enters DONE.
  - A down tick at 00:00 cannot occur, because of the start guard.
- A tick in the same cycle as clear, load or stop is discarded.
- A tick in the same cycle as start is discarded; counting begins with the next tick.
- A tick arriving in IDLE, PAUSE or DONE is discarded.
- Changing `up_down` while in RUN takes effect on the next tick.

## Timing
- A tick is recognised on the first `clk_in` edge that samples `tick_in`=1 after it sampled 0.
- `min_bcd`, `sec_bcd`, `done` and `wrap` are registered and update on that same edge: 1-cycle latency from the rise of `tick_in`.
- Commands take effect on the edge that samples them.
  - `running` and the count reflect the command one cycle after it is asserted.
- `done`, `wrap` and `load_err` are high for exactly one `clk_in` cycle.
- `rst_n` low at any time, including mid-count:
  - all outputs go immediately to their reset values;
  - the state goes to IDLE;
  - `tick_q` goes to 1.

## Structure
- Shared package:
  - state encoding (IDLE, RUN, PAUSE, DONE);
  - constants `SEC_TENS_MAX`=5 and `BCD_MAX`=9;
  - the BCD digit-pair type.
- One sub-module, `bcd_digit`, is natural. It is instantiated 4 times:
  - a mod-(LIMIT+1) BCD digit with inputs for enable, up/down, load and clear;
  - outputs `carry` (digit at LIMIT while counting up) and `borrow` (digit at 0 while counting down).
- The minutes wrap limit comes from MIN_MAX, split into tens and units at elaboration.

## Test plan
- Reset release with `tick_in`=1: no count change on the first edge, and every output reads 0.
- Load 00:58, `up_down`=1, start, then 3 ticks: the count reads 00:59, then 01:00, then 01:01. `running`=1 throughout.
- With MIN_MAX=59, load 59:59, up-count, start, one tick: the count reads 00:00, `wrap` pulses for one cycle, and `running` stays 1.
- Load 00:02, `up_down`=0, start, then 2 ticks: the count reads 00:00. `done` pulses for one cycle, the state is DONE, and `running`=0. A following start is ignored because the count is 00:00 in down mode.
- Command collisions while in RUN:
  - start with stop in the same cycle: the state goes to PAUSE;
  - stop with a tick in the same cycle: the count is unchanged;
  - clear in PAUSE: the count reads 00:00 and the state is IDLE.
- Load preset_sec=8'h60: `load_err` pulses and the count is unchanged. Then assert `rst_n`=0 mid-run: all outputs clear asynchronously.

Source files
------------

// File: rtl/temporizador_mmss_pkg.sv
// temporizador_mmss_pkg: shared state encoding, BCD limits and preset check for the MM:SS timer
package temporizador_mmss_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_e;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] BCD_MAX      = 4'd9;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_pair_t;

    // A preset is usable only if every digit is decimal, seconds stay below 60
    // and the minutes do not exceed the configured wrap point.
    function automatic logic preset_ok(bcd_pair_t m, bcd_pair_t s, logic [6:0] max_min);
        logic [6:0] m_val;
        m_val = {3'b000, m.tens} * 7'd10 + {3'b000, m.units};
        return (m.tens <= BCD_MAX) && (m.units <= BCD_MAX) &&
               (s.tens <= SEC_TENS_MAX) && (s.units <= BCD_MAX) &&
               (m_val <= max_min);
    endfunction

endpackage

// File: rtl/temporizador_mmss_bcd_digit.sv
// bcd_digit: one mod-(LIMIT+1) BCD digit with load, clear and up/down stepping
module bcd_digit
    import temporizador_mmss_pkg::*;
#(
    parameter logic [3:0] LIMIT = BCD_MAX
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       up_i,
    input  logic       load_i,
    input  logic       clear_i,
    input  logic [3:0] load_val_i,
    output logic [3:0] digit_o,
    output logic       carry_o,
    output logic       borrow_o
);

    logic [3:0] digit_q, digit_d;

    assign digit_o  = digit_q;
    assign carry_o  = up_i && (digit_q == LIMIT);
    assign borrow_o = !up_i && (digit_q == 4'd0);

    // Clear beats load beats stepping; stepping rolls over at LIMIT / 0.
    always_comb begin
        digit_d = clear_i ? 4'd0 :
                  load_i  ? load_val_i :
                  !en_i   ? digit_q :
                  up_i    ? (carry_o ? 4'd0 : digit_q + 4'd1) :
                            (borrow_o ? LIMIT : digit_q - 4'd1);
    end

    // Digit register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) digit_q <= 4'd0;
        else        digit_q <= digit_d;
    end

endmodule

// File: rtl/temporizador_mmss.sv
// temporizador_mmss: MM:SS up/down BCD timer advanced by rising edges of the 1 Hz divider output
module temporizador_mmss
    import temporizador_mmss_pkg::*;
#(
    parameter int MIN_MAX = 59
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic       up_down,
    input  logic [7:0] preset_min,
    input  logic [7:0] preset_sec,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       done,
    output logic       wrap,
    output logic       load_err
);

    localparam logic [3:0] MIN_T = 4'(MIN_MAX / 10);
    localparam logic [3:0] MIN_U = 4'(MIN_MAX % 10);

    state_e    state_q, state_d;
    logic      tick_q;
    logic      done_q, done_d;
    logic      wrap_q, wrap_d;
    logic      err_q, err_d;
    logic      tick, step, do_load, do_clear, wrap_clr, clr_all, ld_ok;
    logic      zero_dn, at_max, at_one;
    logic      c_su, b_su, c_st, b_st, c_mu, b_mu, c_mt, b_mt;
    logic      en_st, en_mu, en_mt;
    bcd_pair_t min_w, sec_w, pm, ps;

    assign pm       = preset_min;
    assign ps       = preset_sec;
    assign tick     = tick_in & ~tick_q;
    assign ld_ok    = preset_ok(pm, ps, 7'(MIN_MAX));
    assign zero_dn  = b_su & b_st & b_mu & b_mt;
    assign at_max   = c_mt & (min_w.units == MIN_U) & c_st & c_su;
    assign at_one   = b_mt & b_mu & b_st & (sec_w.units == 4'd1);
    assign en_st    = step & (c_su | b_su);
    assign en_mu    = en_st & (c_st | b_st);
    assign en_mt    = en_mu & (c_mu | b_mu);
    assign clr_all  = do_clear | wrap_clr;
    assign min_bcd  = min_w;
    assign sec_bcd  = sec_w;
    assign running  = (state_q == ST_RUN);
    assign done     = done_q;
    assign wrap     = wrap_q;
    assign load_err = err_q;

    // Command arbitration (clear > load > stop > start > tick) and next state.
    always_comb begin
        state_d  = state_q;
        step     = 1'b0;
        wrap_clr = 1'b0;
        do_clear = 1'b0;
        do_load  = 1'b0;
        done_d   = 1'b0;
        wrap_d   = 1'b0;
        err_d    = 1'b0;
        if (clear) begin
            state_d  = ST_IDLE;
            do_clear = 1'b1;
        end else if (load) begin
            if (ld_ok) begin
                do_load = 1'b1;
                if (state_q == ST_DONE) state_d = ST_IDLE;
            end else begin
                err_d = 1'b1;
            end
        end else if (stop) begin
            if (state_q == ST_RUN) state_d = ST_PAUSE;
        end else if (start) begin
            if (state_q != ST_RUN && !zero_dn) state_d = ST_RUN;
        end else if (state_q == ST_RUN && tick && !zero_dn) begin
            step = 1'b1;
            if (at_max) begin
                wrap_clr = 1'b1;
                wrap_d   = 1'b1;
            end
            if (at_one) begin
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
        end
    end

    // State, edge-detect history and one-cycle status pulses.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tick_q  <= 1'b1;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_in;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    bcd_digit #(.LIMIT(BCD_MAX)) u_sec_u (
        .clk_in(clk_in), .rst_n(rst_n), .en_i(step), .up_i(up_down),
        .load_i(do_load), .clear_i(clr_all), .load_val_i(ps.units),
        .digit_o(sec_w.units), .carry_o(c_su), .borrow_o(b_su)
    );

    bcd_digit #(.LIMIT(SEC_TENS_MAX)) u_sec_t (
        .clk_in(clk_in), .rst_n(rst_n), .en_i(en_st), .up_i(up_down),
        .load_i(do_load), .clear_i(clr_all), .load_val_i(ps.tens),
        .digit_o(sec_w.tens), .carry_o(c_st), .borrow_o(b_st)
    );

    bcd_digit #(.LIMIT(BCD_MAX)) u_min_u (
        .clk_in(clk_in), .rst_n(rst_n), .en_i(en_mu), .up_i(up_down),
        .load_i(do_load), .clear_i(clr_all), .load_val_i(pm.units),
        .digit_o(min_w.units), .carry_o(c_mu), .borrow_o(b_mu)
    );

    bcd_digit #(.LIMIT(MIN_T)) u_min_t (
        .clk_in(clk_in), .rst_n(rst_n), .en_i(en_mt), .up_i(up_down),
        .load_i(do_load), .clear_i(clr_all), .load_val_i(pm.tens),
        .digit_o(min_w.tens), .carry_o(c_mt), .borrow_o(b_mt)
    );

endmodule

// File: tb/tb_temporizador_mmss.sv
// tb_temporizador_mmss: directed and randomized checks of the MM:SS timer against a total-seconds model
module tb_temporizador_mmss;

    localparam int MIN_MAX = 59;
    localparam int SPAN    = (MIN_MAX + 1) * 60;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_in = 1'b1;
    logic       start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0, up_down = 1'b1;
    logic [7:0] preset_min = 8'h00, preset_sec = 8'h00;
    logic [7:0] min_bcd, sec_bcd;
    logic       running, done, wrap, load_err;

    int m_total, m_state, m_prev;
    logic e_done, e_wrap, e_err;
    int ncmp = 0, nfail = 0;

    always #5 clk_in = ~clk_in;

    temporizador_mmss #(.MIN_MAX(MIN_MAX)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in),
        .start(start), .stop(stop), .clear(clear), .load(load), .up_down(up_down),
        .preset_min(preset_min), .preset_sec(preset_sec),
        .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running),
        .done(done), .wrap(wrap), .load_err(load_err)
    );

    function automatic logic [7:0] to_bcd(int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".min"}, min_bcd, to_bcd(m_total / 60));
        chk({tag, ".sec"}, sec_bcd, to_bcd(m_total % 60));
        chk({tag, ".running"}, {7'b0, running}, {7'b0, m_state == S_RUN});
        chk({tag, ".done"}, {7'b0, done}, {7'b0, e_done});
        chk({tag, ".wrap"}, {7'b0, wrap}, {7'b0, e_wrap});
        chk({tag, ".load_err"}, {7'b0, load_err}, {7'b0, e_err});
    endtask

    task automatic model_reset();
        m_total = 0;
        m_state = S_IDLE;
        m_prev  = 1;
        e_done  = 1'b0;
        e_wrap  = 1'b0;
        e_err   = 1'b0;
    endtask

    task automatic step(input string tag, input logic st, input logic sp, input logic cl,
                        input logic ld, input logic tk, input logic ud,
                        input logic [7:0] pm, input logic [7:0] ps);
        int  mt, mu, stn, su;
        bit  t, ok;
        start = st; stop = sp; clear = cl; load = ld; tick_in = tk; up_down = ud;
        preset_min = pm; preset_sec = ps;
        @(posedge clk_in);
        #1;
        t = tk && (m_prev == 0);
        m_prev = int'(tk);
        e_done = 1'b0; e_wrap = 1'b0; e_err = 1'b0;
        mt = int'(pm[7:4]); mu = int'(pm[3:0]); stn = int'(ps[7:4]); su = int'(ps[3:0]);
        ok = (mt <= 9) && (mu <= 9) && (stn <= 5) && (su <= 9) && (mt * 10 + mu <= MIN_MAX);
        if (cl) begin
            m_total = 0;
            m_state = S_IDLE;
        end else if (ld) begin
            if (ok) begin
                m_total = (mt * 10 + mu) * 60 + stn * 10 + su;
                if (m_state == S_DONE) m_state = S_IDLE;
            end else e_err = 1'b1;
        end else if (sp) begin
            if (m_state == S_RUN) m_state = S_PAUSE;
        end else if (st) begin
            if (m_state != S_RUN && !(ud == 1'b0 && m_total == 0)) m_state = S_RUN;
        end else if (t && m_state == S_RUN) begin
            if (ud) begin
                m_total = (m_total + 1) % SPAN;
                e_wrap = (m_total == 0);
            end else if (m_total > 0) begin
                m_total--;
                if (m_total == 0) begin
                    e_done = 1'b1;
                    m_state = S_DONE;
                end
            end
        end
        check_all(tag);
    endtask

    task automatic cyc(input string tag, input logic tk);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, tk, up_down, preset_min, preset_sec);
    endtask

    task automatic tick1(input string tag);
        cyc(tag, 1'b1);
        cyc(tag, 1'b0);
        cyc(tag, 1'b0);
    endtask

    task automatic async_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        tick_in = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        cyc({tag, ".rel"}, 1'b1);
    endtask

    initial begin
        int hold;
        logic lvl;
        logic ud;
        logic [7:0] pm, ps;
        model_reset();
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        cyc("rst_rel", 1'b1);
        cyc("rst_low", 1'b0);

        step("ld0058", 0, 0, 0, 1, 0, 1, 8'h00, 8'h58);
        step("start_up", 1, 0, 0, 0, 0, 1, 8'h00, 8'h58);
        repeat (3) tick1("up_ticks");

        step("ld5959", 0, 0, 0, 1, 0, 1, 8'h59, 8'h59);
        tick1("wrap");
        tick1("after_wrap");

        step("ld0002", 0, 0, 0, 1, 0, 0, 8'h00, 8'h02);
        tick1("dn1");
        tick1("dn_done");
        step("start_guard", 1, 0, 0, 0, 0, 0, 8'h00, 8'h02);
        tick1("done_idle");

        step("ld0010", 0, 0, 0, 1, 0, 1, 8'h00, 8'h10);
        step("start_tick", 1, 0, 0, 0, 1, 1, 8'h00, 8'h10);
        cyc("start_tick_lo", 1'b0);
        tick1("run_tick");
        step("start_stop", 1, 1, 0, 0, 0, 1, 8'h00, 8'h10);
        tick1("pause_tick");
        step("resume", 1, 0, 0, 0, 0, 1, 8'h00, 8'h10);
        step("stop_tick", 0, 1, 0, 0, 1, 1, 8'h00, 8'h10);
        cyc("stop_tick_lo", 1'b0);
        step("clear", 0, 0, 1, 0, 0, 1, 8'h00, 8'h10);

        step("ld_bad_sec", 0, 0, 0, 1, 0, 1, 8'h01, 8'h60);
        cyc("err_gone", 1'b0);
        step("ld_bad_min", 0, 0, 0, 1, 0, 1, 8'h60, 8'h00);
        step("ld_bad_dig", 0, 0, 0, 1, 0, 1, 8'h0A, 8'h00);
        step("ld1230", 0, 0, 0, 1, 0, 0, 8'h12, 8'h30);
        step("start_dn", 1, 0, 0, 0, 0, 0, 8'h12, 8'h30);
        repeat (2) tick1("dn_mid");
        async_reset("async_rst");

        lvl = 1'b0;
        hold = 3;
        ud = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (hold == 0) begin
                lvl = ~lvl;
                hold = lvl ? $urandom_range(1, 5) : $urandom_range(2, 9);
            end
            hold--;
            if ($urandom_range(0, 199) == 0) ud = ~ud;
            pm = ($urandom_range(0, 1) == 0) ? 8'h00 :
                 {4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))};
            ps = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))};
            step("rand", $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 299) == 0, $urandom_range(0, 79) == 0, lvl, ud, pm, ps);
            if (i == 2500) async_reset("rand_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
